id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 16-bit ALU.
- Registers decoded operands and control at the ID→EX boundary, then resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Drives the ALU X, Y, opcod and Cin inputs and carries the destination register and write-enable forward.
- Supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 16, operand/result width.
- REG_AW, 3, register-address width (8-entry register file; register 0 is hardwired zero).
- OP_W, 3, ALU operation-select width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  replace the stage contents with a bubble.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs_addr  in  REG_AW  source register 1 address.
- id_rt_addr  in  REG_AW  source register 2 address.
- id_rd_addr  in  REG_AW  destination register address.
- id_rs_data  in  DATA_W  register file read data 1.
- id_rt_data  in  DATA_W  register file read data 2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_alusrc  in  1  1 = Y takes the immediate.
- id_opcod  in  OP_W  ALU operation select.
- id_cin  in  1  ALU carry-in (1 for subtract).
- id_regwrite  in  1  instruction writes rd.
- exm_regwrite  in  1  EX/MEM instruction writes its rd.
- exm_rd  in  REG_AW  EX/MEM destination register.
- exm_result  in  DATA_W  EX/MEM ALU result.
- wb_regwrite  in  1  MEM/WB instruction writes its rd.
- wb_rd  in  REG_AW  MEM/WB destination register.
- wb_result  in  DATA_W  MEM/WB write-back value.
- ex_x  out  DATA_W  ALU X operand (forwarded).
- ex_y  out  DATA_W  ALU Y operand (forwarded rt or immediate).
- ex_store_data  out  DATA_W  forwarded rt value, for stores.
- ex_opcod  out  OP_W  registered opcod.
- ex_cin  out  1  registered Cin.
- ex_rd  out  REG_AW  registered destination register.
- ex_regwrite  out  1  registered regwrite, gated by valid.
- ex_valid  out  1  EX slot holds a real instruction.
- fwd_x_sel  out  2  X source: 00 = register, 01 = EX/MEM, 10 = MEM/WB.
- fwd_y_sel  out  2  rt source, same encoding (reflects the rt path even when alusrc = 1).

Behaviour:
- Reset: on rst high, all stage registers clear to 0 immediately, without waiting for clk. Consequently ex_valid = 0, ex_regwrite = 0, ex_opcod = 0, ex_cin = 0, ex_rd = 0, fwd_*_sel = 00, and ex_x = ex_y = ex_store_data = 0. Reset asserted mid-operation discards the in-flight instruction.
- Capture: on each rising clk edge, priority is rst > flush > stall > load.
  - load: every id_* field is registered. The valid register takes id_valid; the regwrite register takes id_regwrite & id_valid.
  - stall: all registers hold their values.
  - flush: valid, regwrite, opcod, cin, rd, rs_addr and rt_addr clear to 0; data registers clear to 0.
  - flush and stall in the same cycle: flush wins.
- Latency: ID inputs appear on the ex_* outputs 1 cycle after capture. The forwarding path is purely combinational from the registered addresses and the exm_*/wb_* inputs, within the same cycle.
- Forwarding rule (rs path shown; the rt path is identical using the stored rt address):
  - Select EX/MEM if exm_regwrite = 1, exm_rd != 0 and exm_rd == stored rs.
  - Otherwise select MEM/WB if wb_regwrite = 1, wb_rd != 0 and wb_rd == stored rs.
  - Otherwise use the registered read data.
  - EX/MEM has priority when both stages match.
  - Register 0 is never forwarded, so it always reads the registered value.
- ex_y = registered immediate if alusrc = 1, else the forwarded rt. ex_store_data is always the forwarded rt.
- During stall, the outputs keep re-evaluating forwarding against the current exm/wb inputs. The held instruction therefore sees the newest producer values.
- No arithmetic is performed: values are passed at full DATA_W width, with no truncation or extension.

Test Plan:
- rst pulsed between clk edges with prior non-zero contents → all outputs 0 asynchronously, before the next clk edge.
- Load rs=2 (data 0x1111), rt=3 (data 0x2222), alusrc=0; exm_rd=2, exm_regwrite=1, exm_result=0xAAAA → next cycle ex_x=0xAAAA, fwd_x_sel=01, ex_y=0x2222, fwd_y_sel=00.
- exm_rd=3 (result 0x5555) and wb_rd=3 (result 0x6666), both regwrite=1, stored rt=3 → ex_y=0x5555, fwd_y_sel=01. With exm_regwrite=0 instead → ex_y=0x6666, fwd_y_sel=10.
- Stored rs=0 with exm_rd=0, exm_regwrite=1, exm_result=0xFFFF → ex_x equals the registered rs data, fwd_x_sel=00.
- Load a valid instruction, then assert stall for 3 cycles while id_* inputs change → ex_opcod/ex_rd/ex_valid unchanged. Then stall=1 and flush=1 together → ex_valid=0, ex_regwrite=0, ex_opcod=0.
- alusrc=1 with imm=0xFFF0 and an rt forwarding match from wb_result=0x0042 → ex_y=0xFFF0, ex_store_data=0x0042, fwd_y_sel=10.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU, with EX/MEM and MEM/WB operand forwarding.
// Supports hazard-unit stall (hold) and flush (bubble insertion).
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic [OP_W-1:0]   id_opcod,
    input  logic              id_cin,
    input  logic              id_regwrite,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] ex_x,
    output logic [DATA_W-1:0] ex_y,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [OP_W-1:0]   ex_opcod,
    output logic              ex_cin,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_valid,
    output logic [1:0]        fwd_x_sel,
    output logic [1:0]        fwd_y_sel
);

    logic              valid_q;
    logic              regwrite_q;
    logic [OP_W-1:0]   opcod_q;
    logic              cin_q;
    logic              alusrc_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] rt_fwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            // flush shares the reset image so a bubble never forwards or writes
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            opcod_q    <= '0;
            cin_q      <= 1'b0;
            alusrc_q   <= 1'b0;
            rd_q       <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            regwrite_q <= id_regwrite & id_valid;
            opcod_q    <= id_opcod;
            cin_q      <= id_cin;
            alusrc_q   <= id_alusrc;
            rd_q       <= id_rd_addr;
            rs_addr_q  <= id_rs_addr;
            rt_addr_q  <= id_rt_addr;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
        end
    end

    // EX/MEM wins over MEM/WB; register 0 never forwards
    always_comb begin
        fwd_x_sel = 2'b00;
        if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs_addr_q)) begin
            fwd_x_sel = 2'b01;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_addr_q)) begin
            fwd_x_sel = 2'b10;
        end

        fwd_y_sel = 2'b00;
        if (exm_regwrite && (exm_rd != '0) && (exm_rd == rt_addr_q)) begin
            fwd_y_sel = 2'b01;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_addr_q)) begin
            fwd_y_sel = 2'b10;
        end
    end

    always_comb begin
        case (fwd_x_sel)
            2'b01:   ex_x = exm_result;
            2'b10:   ex_x = wb_result;
            default: ex_x = rs_data_q;
        endcase

        case (fwd_y_sel)
            2'b01:   rt_fwd = exm_result;
            2'b10:   rt_fwd = wb_result;
            default: rt_fwd = rt_data_q;
        endcase
    end

    assign ex_y          = alusrc_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_opcod      = opcod_q;
    assign ex_cin        = cin_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q & valid_q;
    assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected output images, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        id_valid;
    logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc;
    logic [2:0]  id_opcod;
    logic        id_cin, id_regwrite;
    logic        exm_regwrite;
    logic [2:0]  exm_rd;
    logic [15:0] exm_result;
    logic        wb_regwrite;
    logic [2:0]  wb_rd;
    logic [15:0] wb_result;
    logic [15:0] ex_x, ex_y, ex_store_data;
    logic [2:0]  ex_opcod;
    logic        ex_cin;
    logic [2:0]  ex_rd;
    logic        ex_regwrite, ex_valid;
    logic [1:0]  fwd_x_sel, fwd_y_sel;

    // {valid, regwrite, opcod, cin, rd, x, y, store_data, fwd_x_sel, fwd_y_sel}
    typedef logic [60:0] img_t;

    img_t  exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;

    id_ex_stage #(.DATA_W(16), .REG_AW(3), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_opcod(id_opcod), .id_cin(id_cin),
        .id_regwrite(id_regwrite), .exm_regwrite(exm_regwrite), .exm_rd(exm_rd),
        .exm_result(exm_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_result(wb_result), .ex_x(ex_x), .ex_y(ex_y), .ex_store_data(ex_store_data),
        .ex_opcod(ex_opcod), .ex_cin(ex_cin), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_valid(ex_valid), .fwd_x_sel(fwd_x_sel), .fwd_y_sel(fwd_y_sel)
    );

    always #5 clk = ~clk;

    function automatic img_t img(input logic v, input logic rw, input logic [2:0] op,
                                 input logic cin, input logic [2:0] rd, input logic [15:0] x,
                                 input logic [15:0] y, input logic [15:0] sd,
                                 input logic [1:0] fx, input logic [1:0] fy);
        return {v, rw, op, cin, rd, x, y, sd, fx, fy};
    endfunction

    // Monitor: compare one queued expectation per falling edge, away from the active edge.
    initial begin
        img_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {ex_valid, ex_regwrite, ex_opcod, ex_cin, ex_rd, ex_x, ex_y,
                     ex_store_data, fwd_x_sel, fwd_y_sel};
                tests++;
                if (a !== e) begin
                    failed++;
                    $display("FAIL %s: got %h required %h", n, a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input img_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL %s: monitor timeout, got no comparison required one", n);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
        id_opcod = 0; id_cin = 0; id_regwrite = 0;
        exm_regwrite = 0; exm_rd = 0; exm_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic load(input logic v, input logic [2:0] rs, input logic [15:0] rsd,
                        input logic [2:0] rt, input logic [15:0] rtd, input logic [2:0] rd,
                        input logic [15:0] imm, input logic as, input logic [2:0] op,
                        input logic cin, input logic rw);
        id_valid = v; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
        id_rd_addr = rd; id_imm = imm; id_alusrc = as; id_opcod = op; id_cin = cin;
        id_regwrite = rw;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        idle_inputs();
        tick(); tick();
        rst = 0;
        check("reset", img(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        // EX/MEM forwarding on X
        load(1, 2, 16'h1111, 3, 16'h2222, 5, 16'h0007, 0, 3'd2, 0, 1);
        tick();
        stall = 1;
        exm_regwrite = 1; exm_rd = 2; exm_result = 16'hAAAA;
        check("fwd_exm_x", img(1, 1, 2, 0, 5, 16'hAAAA, 16'h2222, 16'h2222, 2'b01, 2'b00));

        // Both stages match rt; EX/MEM has priority, then MEM/WB alone
        exm_rd = 3; exm_result = 16'h5555;
        wb_regwrite = 1; wb_rd = 3; wb_result = 16'h6666;
        check("prio_exm_y", img(1, 1, 2, 0, 5, 16'h1111, 16'h5555, 16'h5555, 2'b00, 2'b01));
        exm_regwrite = 0;
        check("fwd_wb_y", img(1, 1, 2, 0, 5, 16'h1111, 16'h6666, 16'h6666, 2'b00, 2'b10));

        // Stall holds across 3 edges while ID inputs change
        wb_regwrite = 0;
        load(0, 7, 16'hDEAD, 6, 16'hBEEF, 1, 16'h1234, 1, 3'd7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold",
                  img(1, 1, 2, 0, 5, 16'h1111, 16'h2222, 16'h2222, 2'b00, 2'b00));
        end

        // Flush beats stall
        flush = 1;
        tick();
        flush = 0; stall = 0;
        check("stall_flush", img(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        // Register 0 is never forwarded
        load(1, 0, 16'h1234, 4, 16'h4444, 6, 16'h0000, 0, 3'd1, 1, 1);
        tick();
        stall = 1;
        exm_regwrite = 1; exm_rd = 0; exm_result = 16'hFFFF;
        wb_regwrite = 1; wb_rd = 0; wb_result = 16'hEEEE;
        check("r0_no_fwd", img(1, 1, 1, 1, 6, 16'h1234, 16'h4444, 16'h4444, 2'b00, 2'b00));

        // Immediate on Y while store data still takes the forwarded rt
        stall = 0;
        exm_regwrite = 0; exm_rd = 0; wb_regwrite = 0; wb_rd = 0;
        load(1, 1, 16'h0101, 5, 16'h0505, 7, 16'hFFF0, 1, 3'd4, 0, 1);
        tick();
        stall = 1;
        wb_regwrite = 1; wb_rd = 5; wb_result = 16'h0042;
        check("alusrc_imm", img(1, 1, 4, 0, 7, 16'h0101, 16'hFFF0, 16'h0042, 2'b00, 2'b10));

        // regwrite gated by valid
        stall = 0; wb_regwrite = 0; wb_rd = 0;
        load(0, 3, 16'h3333, 0, 16'h0000, 2, 16'h0000, 0, 3'd5, 0, 1);
        tick();
        stall = 1;
        check("rw_gated", img(0, 0, 5, 0, 2, 16'h3333, 16'h0000, 16'h0000, 2'b00, 2'b00));

        // X from MEM/WB, Y from EX/MEM simultaneously
        stall = 0;
        load(1, 6, 16'h6060, 7, 16'h7070, 4, 16'h0000, 0, 3'd3, 0, 1);
        tick();
        stall = 1;
        exm_regwrite = 1; exm_rd = 7; exm_result = 16'h7777;
        wb_regwrite = 1; wb_rd = 6; wb_result = 16'h6666;
        check("fwd_mixed", img(1, 1, 3, 0, 4, 16'h6666, 16'h7777, 16'h7777, 2'b10, 2'b01));

        // Flush alone inserts a bubble over a valid ID instruction
        stall = 0; flush = 1;
        load(1, 6, 16'h1010, 7, 16'h2020, 3, 16'h0000, 0, 3'd6, 1, 1);
        tick();
        flush = 0; stall = 1;
        check("flush_only", img(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        // Asynchronous reset between edges discards the in-flight instruction
        stall = 0;
        exm_regwrite = 0; exm_rd = 0; wb_regwrite = 0; wb_rd = 0;
        load(1, 2, 16'h2468, 3, 16'h1357, 5, 16'h0000, 0, 3'd7, 1, 1);
        tick();
        rst = 1;
        check("async_rst", img(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
